// File: rtl/mem_arbiter.sv
// mem_arbiter: merges instruction/data request streams onto one memory port, one outstanding transaction.
// Optional MEM_ARBITER_ROUND_ROBIN_EN alternates tie winners; default build is fixed data-side priority.
module mem_arbiter #(
   parameter bit bypass_enable = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_valid,
   input  logic        imem_instr,
   input  logic [31:0] imem_addr,
   input  logic [31:0] imem_wdata,
   input  logic [3:0]  imem_wstrb,
   output logic [31:0] imem_rdata,
   output logic        imem_ready,
   input  logic        dmem_valid,
   input  logic        dmem_instr,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_rdata,
   output logic        dmem_ready,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;
   state_t state, state_nx;
   req_t   pi, pd, q, w, ilive, dlive;
   logic   pi_v, pd_v, ic, dc, idle, tie, gnt_i, gnt_d, i_fill, d_fill, prio_d;
   assign ilive = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
   assign dlive = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};
`ifndef MEM_ARBITER_ROUND_ROBIN_EN
   assign prio_d = 1'b1;
`endif
   // grant depends only on state, slots and request inputs, never on mem_ready
   always_comb begin
      idle     = state == IDLE;
      ic       = pi_v | (bypass_enable & imem_valid);
      dc       = pd_v | (bypass_enable & dmem_valid);
      tie      = idle & ic & dc;
      gnt_d    = idle & dc & (~ic | prio_d);
      gnt_i    = idle & ic & ~gnt_d;
      w        = gnt_d ? (pd_v ? pd : dlive) : (pi_v ? pi : ilive);
      mem_valid = gnt_i | gnt_d;
      {mem_instr, mem_addr, mem_wdata, mem_wstrb} = mem_valid ? w : q;
      i_fill   = imem_valid & ~pi_v & ~gnt_i & ~(state == BUSY_I & ~mem_ready);
      d_fill   = dmem_valid & ~pd_v & ~gnt_d & ~(state == BUSY_D & ~mem_ready);
      imem_ready = state == BUSY_I & mem_ready;
      dmem_ready = state == BUSY_D & mem_ready;
      imem_rdata = imem_ready ? mem_rdata : 32'd0;
      dmem_rdata = dmem_ready ? mem_rdata : 32'd0;
      state_nx = gnt_d ? BUSY_D : gnt_i ? BUSY_I : (~idle & mem_ready) ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         pi_v  <= 1'b0;
         pd_v  <= 1'b0;
         pi    <= '0;
         pd    <= '0;
         q     <= '0;
      end else begin
         state <= state_nx;
         pi_v  <= i_fill | (pi_v & ~gnt_i);
         pd_v  <= d_fill | (pd_v & ~gnt_d);
         if (i_fill) pi <= ilive;
         if (d_fill) pd <= dlive;
         if (mem_valid) q <= w;
      end
   end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   // pointer moves only on contested grants so the loser of a tie wins the next one
   always_ff @(posedge clk) begin
      if (!rst) prio_d <= 1'b1;
      else if (tie) prio_d <= ~gnt_d;
   end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter, bypass and registered instances sharing stimulus.
module tb_mem_arbiter;
   typedef struct packed {
      logic        d;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;
   logic        clk = 0, rst = 0, sel = 0;
   logic        imem_valid = 0, imem_instr = 0, dmem_valid = 0, dmem_instr = 0, mem_ready = 0;
   logic [31:0] imem_addr = 0, imem_wdata = 0, dmem_addr = 0, dmem_wdata = 0, mem_rdata = 0;
   logic [3:0]  imem_wstrb = 0, dmem_wstrb = 0;
   logic [31:0] a_irdata, a_drdata, a_addr, a_wdata, b_irdata, b_drdata, b_addr, b_wdata;
   logic        a_iready, a_dready, a_valid, a_instr, b_iready, b_dready, b_valid, b_instr;
   logic [3:0]  a_wstrb, b_wstrb;
   logic [68:0] o_req;
   logic [31:0] o_irdata, o_drdata;
   logic        o_valid, o_iready, o_dready;
   exp_t        q[$];
   exp_t        ei, ed;
   int          total = 0, bad = 0;
   logic        s;
   always #5 clk = ~clk;
   mem_arbiter #(.bypass_enable(1'b1)) ua (
      .clk(clk), .rst(rst),
      .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .imem_wstrb(imem_wstrb), .imem_rdata(a_irdata), .imem_ready(a_iready),
      .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb), .dmem_rdata(a_drdata), .dmem_ready(a_dready),
      .mem_valid(a_valid), .mem_instr(a_instr), .mem_addr(a_addr), .mem_wdata(a_wdata),
      .mem_wstrb(a_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );
   mem_arbiter #(.bypass_enable(1'b0)) ub (
      .clk(clk), .rst(rst),
      .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .imem_wstrb(imem_wstrb), .imem_rdata(b_irdata), .imem_ready(b_iready),
      .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb), .dmem_rdata(b_drdata), .dmem_ready(b_dready),
      .mem_valid(b_valid), .mem_instr(b_instr), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .mem_wstrb(b_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );
   assign o_valid  = sel ? b_valid : a_valid;
   assign o_req    = sel ? {b_instr, b_addr, b_wdata, b_wstrb} : {a_instr, a_addr, a_wdata, a_wstrb};
   assign o_iready = sel ? b_iready : a_iready;
   assign o_dready = sel ? b_dready : a_dready;
   assign o_irdata = sel ? b_irdata : a_irdata;
   assign o_drdata = sel ? b_drdata : a_drdata;

   task tick;
      @(negedge clk);
      imem_valid = 0;
      dmem_valid = 0;
      mem_ready  = 0;
      mem_rdata  = 0;
   endtask

   task do_reset;
      rst = 0;
      repeat (2) tick;
      rst = 1;
   endtask

   task req(input logic d, input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
            input logic [3:0] wstrb);
      if (d) begin
         dmem_valid = 1; dmem_instr = instr; dmem_addr = addr; dmem_wdata = wdata; dmem_wstrb = wstrb;
         ed = {1'b1, instr, addr, wdata, wstrb};
      end else begin
         imem_valid = 1; imem_instr = instr; imem_addr = addr; imem_wdata = wdata; imem_wstrb = wstrb;
         ei = {1'b0, instr, addr, wdata, wstrb};
      end
   endtask

   // waits (bounded) for mem_valid on the selected instance and checks it against the scoreboard head
   task expect_issue(input int want_wait, input string nm, output logic side);
      int w;
      exp_t e;
      w = 0;
      side = 0;
      #1;
      while (!o_valid && w < 20) begin
         tick;
         #1;
         w++;
      end
      total++;
      if (!o_valid || q.size() == 0) begin
         bad++;
         $display("FAIL %s: no issue (valid=%b queued=%0d)", nm, o_valid, q.size());
         return;
      end
      e = q.pop_front();
      side = e.d;
      total++;
      if (o_req !== {e.instr, e.addr, e.wdata, e.wstrb}) begin
         bad++;
         $display("FAIL %s fields: got %h want %h", nm, o_req, {e.instr, e.addr, e.wdata, e.wstrb});
      end
      total++;
      if (w !== want_wait) begin
         bad++;
         $display("FAIL %s latency: got %0d want %0d", nm, w, want_wait);
      end
   endtask

   task complete(input int lat, input logic side, input logic [31:0] rd, input string nm);
      logic [65:0] want;
      repeat (lat) tick;
      mem_ready = 1;
      mem_rdata = rd;
      want = side ? {1'b0, 32'd0, 1'b1, rd} : {1'b1, rd, 1'b0, 32'd0};
      #1;
      total++;
      if ({o_iready, o_irdata, o_dready, o_drdata} !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, {o_iready, o_irdata, o_dready, o_drdata}, want);
      end
      tick;
   endtask

   task test_reset;
      repeat (2) tick;
      #1;
      total++;
      if ({a_valid, a_instr, a_addr, a_wdata, a_wstrb, a_iready, a_irdata, a_dready, a_drdata,
           b_valid, b_instr, b_addr, b_wdata, b_wstrb, b_iready, b_irdata, b_dready, b_drdata} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: nonzero output a_valid=%b a_addr=%h b_valid=%b b_addr=%h",
                  a_valid, a_addr, b_valid, b_addr);
      end
      rst = 1;
      tick;
      mem_ready = 1;
      mem_rdata = 32'h1234;
      #1;
      total++;
      if ({a_iready, a_dready, b_iready, b_dready} !== 4'b0) begin
         bad++;
         $display("FAIL idle_ready_ignored: got %b want 0000", {a_iready, a_dready, b_iready, b_dready});
      end
      tick;
   endtask

   task test_bypass;
      sel = 0;
      do_reset;
      req(0, 1, 32'h100, 32'h0, 4'h0);
      q.push_back(ei);
      expect_issue(0, "bypass_issue", s);
      complete(3, s, 32'hDEADBEEF, "bypass_ready");
   endtask

   task test_collision;
      sel = 0;
      do_reset;
      req(0, 1, 32'h300, 32'h0, 4'h0);
      req(1, 0, 32'h2000, 32'h12345678, 4'hF);
      q.push_back(ed);
      q.push_back(ei);
      expect_issue(0, "coll_first", s);
      complete(2, s, 32'hA5A5A5A5, "coll_first_ready");
      expect_issue(0, "coll_second", s);
      complete(1, s, 32'h5A5A5A5A, "coll_second_ready");
   endtask

   task test_priority;
      sel = 0;
      do_reset;
      for (int r = 0; r < 3; r++) begin
         req(0, 1, 32'h1000 + 32'(r * 16), 32'h0, 4'h0);
         req(1, 0, 32'h2000 + 32'(r * 16), 32'hA0 + 32'(r), 4'h1);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         if (r == 1) begin
            q.push_back(ei);
            q.push_back(ed);
         end else begin
            q.push_back(ed);
            q.push_back(ei);
         end
`else
         q.push_back(ed);
         q.push_back(ei);
`endif
         expect_issue(0, "prio_first", s);
         complete(1, s, 32'hB0 + 32'(r), "prio_first_ready");
         expect_issue(0, "prio_second", s);
         complete(1, s, 32'hC0 + 32'(r), "prio_second_ready");
      end
   endtask

   task test_registered;
      sel = 1;
      do_reset;
      req(1, 0, 32'h40, 32'hCAFEF00D, 4'b0011);
      q.push_back(ed);
      expect_issue(1, "reg_issue", s);
      complete(2, s, 32'h0BADF00D, "reg_ready");
      sel = 0;
   endtask

   task test_back_to_back;
      sel = 0;
      do_reset;
      req(1, 0, 32'h700, 32'h0, 4'h0);
      q.push_back(ed);
      expect_issue(0, "b2b_first", s);
      tick;
      req(0, 1, 32'h600, 32'h0, 4'h0);
      q.push_back(ei);
      mem_ready = 1;
      mem_rdata = 32'h600DCAFE;
      #1;
      total++;
      if ({o_dready, o_drdata, o_iready} !== {1'b1, 32'h600DCAFE, 1'b0}) begin
         bad++;
         $display("FAIL b2b_ready: got %h want %h", {o_dready, o_drdata, o_iready}, {1'b1, 32'h600DCAFE, 1'b0});
      end
      tick;
      expect_issue(0, "b2b_second", s);
      complete(1, s, 32'h11112222, "b2b_second_ready");
   endtask

   task test_midreset;
      sel = 0;
      do_reset;
      req(1, 0, 32'h80, 32'h0, 4'h0);
      q.push_back(ed);
      expect_issue(0, "mid_issue", s);
      tick;
      req(0, 1, 32'h500, 32'h0, 4'h0);
      tick;
      rst = 0;
      tick;
      #1;
      total++;
      if ({o_valid, o_req, o_iready, o_irdata, o_dready, o_drdata} !== '0) begin
         bad++;
         $display("FAIL mid_reset_outputs: valid=%b req=%h iready=%b dready=%b", o_valid, o_req, o_iready, o_dready);
      end
      rst = 1;
      mem_ready = 1;
      mem_rdata = 32'h77;
      #1;
      total++;
      if ({o_iready, o_dready, o_valid} !== 3'b0) begin
         bad++;
         $display("FAIL late_ready: got %b want 000", {o_iready, o_dready, o_valid});
      end
      repeat (3) begin
         tick;
         #1;
         total++;
         if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL pending_discarded: mem_valid=%b want 0", o_valid);
         end
      end
   endtask

   initial begin
      test_reset;
      test_bypass;
      test_collision;
      test_priority;
      test_registered;
      test_back_to_back;
      test_midreset;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d left want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
